eth_tx_framer: RTL and testbench

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

---
 rtl/eth_tx_framer.sv | 184 ++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: wraps a client byte stream with preamble/SFD,
// zero-pads short frames, appends the CRC-32 FCS and enforces the
// inter-frame gap. A client underrun aborts the frame without an FCS.

package eth_tx_pkg;
  // Reflected CRC-32 (poly 0x04C11DB7), one byte in, LSB first.
  function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction
endpackage

module eth_tx_framer #(
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES       = 12   // must be at least 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        frame_done,
  output logic [10:0] frame_len,
  output logic        tx_err
);
  import eth_tx_pkg::*;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG
  } state_t;

  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_BYTES);
  localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);

  state_t      state;
  logic [31:0] crc;
  logic [10:0] byte_cnt;
  logic [2:0]  sub_cnt;    // preamble byte index, then FCS byte index
  logic [15:0] ifg_cnt;

  logic [10:0] cnt_inc;
  logic [7:0]  crc_in;
  logic [31:0] crc_nxt;
  logic [7:0]  fcs_byte;

  // Byte counter saturates so oversized frames cannot wrap into a short length.
  assign cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign crc_in  = (state == PAD) ? 8'h00 : in_data;
  assign crc_nxt = crc32_next(crc, crc_in);

  // Select the FCS byte on the line: inverted CRC, least significant byte first.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    fcs_byte = 8'h00;
    case (sub_cnt[1:0])
      2'd0: fcs_byte = ~crc[7:0];
      2'd1: fcs_byte = ~crc[15:8];
      2'd2: fcs_byte = ~crc[23:16];
      2'd3: fcs_byte = ~crc[31:24];
      default: fcs_byte = 8'h00;
    endcase
  end

  // Line-side outputs decoded from the state; DATA is a straight pass-through
  // so client backpressure costs no extra cycle.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    in_ready = 1'b0;
    case (state)
      PREAMBLE: begin tx_valid = 1'b1;     tx_data = 8'h55;   end
      SFD:      begin tx_valid = 1'b1;     tx_data = 8'hD5;   end
      DATA:     begin tx_valid = in_valid; tx_data = in_data; in_ready = tx_ready; end
      PAD:      begin tx_valid = 1'b1;     tx_data = 8'h00;   end
      FCS:      begin tx_valid = 1'b1;     tx_data = fcs_byte; end
      DRAIN:    in_ready = 1'b1;
      default:  ;
    endcase
  end

  // Framing FSM; every step except IDLE entry and DRAIN waits on tx_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the CRC accumulator is reset as well so a frame cut by reset can never leak its partial CRC.
      state      <= IDLE;
      crc        <= '1;
      byte_cnt   <= '0;
      sub_cnt    <= '0;
      ifg_cnt    <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      tx_err     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      frame_done <= 1'b0;
      tx_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state   <= PREAMBLE;
            sub_cnt <= '0;
          end
        end
        PREAMBLE: begin
          if (tx_ready) begin
            if (sub_cnt == 3'd6) begin
              sub_cnt <= '0;
              state   <= SFD;
            end else begin
              sub_cnt <= sub_cnt + 3'd1;
            end
          end
        end
        SFD: begin
          if (tx_ready) begin
            crc      <= '1;
            byte_cnt <= '0;
            state    <= DATA;
          end
        end
        DATA: begin
          if (tx_ready) begin
            if (in_valid) begin
              crc      <= crc_nxt;
              byte_cnt <= cnt_inc;
              if (in_last) begin
                sub_cnt <= '0;
                state   <= (cnt_inc < MIN_LEN) ? PAD : FCS;
              end
            end else begin
              // Client starved the line mid-frame: abort without an FCS.
              tx_err <= 1'b1;
              state  <= DRAIN;
            end
          end
        end
        PAD: begin
          if (tx_ready) begin
            crc      <= crc_nxt;
            byte_cnt <= cnt_inc;
            sub_cnt  <= '0;
            if (cnt_inc >= MIN_LEN) state <= FCS;
          end
        end
        FCS: begin
          if (tx_ready) begin
            if (sub_cnt == 3'd3) begin
              frame_done <= 1'b1;
              frame_len  <= byte_cnt;
              ifg_cnt    <= '0;
              state      <= IFG;
            end else begin
              sub_cnt <= sub_cnt + 3'd1;
            end
          end
        end
        DRAIN: begin
          // Nothing goes to the line here, so discarding does not wait on tx_ready.
          if (in_valid && in_last) begin
            ifg_cnt <= '0;
            state   <= IFG;
          end
        end
        IFG: begin
          if (tx_ready) begin
            if (ifg_cnt == IFG_LAST) state <= IDLE;
            else                     ifg_cnt <= ifg_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Scoreboard bench for eth_tx_framer: stimulus pushes expected line bytes and
// frame events into queues; a monitor pops and compares on every transfer.

module tb_eth_tx_framer;
  localparam int MIN_FRAME_BYTES = 60;
  localparam int IFG_BYTES       = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        frame_done;
  logic [10:0] frame_len;
  logic        tx_err;

  eth_tx_framer #(.MIN_FRAME_BYTES(MIN_FRAME_BYTES), .IFG_BYTES(IFG_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_done(frame_done), .frame_len(frame_len), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  typedef enum bit {EV_DONE, EV_ERR} ev_kind_t;
  typedef struct { ev_kind_t kind; logic [10:0] len; } ev_t;

  logic [7:0] exp_q[$];
  ev_t        ev_q[$];
  int total = 0;
  int bad   = 0;
  bit rand_ready = 1'b0;
  int idle_run = 0;
  int last_gap = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, req);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got=timeout/unexpected want=event", name);
  endtask

  // Bit-serial CRC-32 reference: one input bit per shift, LSB first.
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  function automatic logic [7:0] byte_of(input int seed, input int i);
    return 8'(i * 29 + seed * 53 + 7);
  endfunction

  // Expected line bytes for one frame; drop >= 0 means underrun after that many bytes.
  task automatic expect_frame(input int n, input int seed, input int drop);
    logic [31:0] c;
    logic [7:0]  b;
    int len;
    c = '1;
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    if (drop >= 0) begin
      for (int i = 0; i < drop; i++) exp_q.push_back(byte_of(seed, i));
      ev_q.push_back('{EV_ERR, 11'd0});
      return;
    end
    for (int i = 0; i < n; i++) begin
      b = byte_of(seed, i);
      exp_q.push_back(b);
      c = model_crc(c, b);
    end
    len = n;
    while (len < MIN_FRAME_BYTES) begin
      exp_q.push_back(8'h00);
      c = model_crc(c, 8'h00);
      len++;
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
    ev_q.push_back('{EV_DONE, 11'(len)});
  endtask

  // Offer n bytes; leaves in_valid high after the last one (caller clears it).
  task automatic drive_frame(input int n, input int seed, input int drop, output int accepted);
    bit acc;
    int budget;
    accepted = 0;
    for (int i = 0; i < n; i++) begin
      if (i == drop) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = byte_of(seed, i);
      in_last  = (i == n - 1);
      acc = 1'b0;
      budget = 0;
      while (!acc && budget < 2000) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        budget++;
      end
      if (!acc) begin
        flag("input_accept");
        return;
      end
      accepted++;
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || ev_q.size() != 0) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    check(name, 32'(exp_q.size() + ev_q.size()), 32'd0);
    repeat (IFG_BYTES + 4) @(posedge clk);
    #1;
  endtask

  // Line-side ready: held high, or random per cycle while rand_ready is set.
  initial begin
    forever begin
      @(posedge clk); #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expectations on every transfer and every event pulse.
  initial begin
    logic [7:0] e;
    ev_t ev;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_run = 0;
      end else begin
        if (tx_valid) begin
          if (idle_run > 0) last_gap = idle_run;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) flag("tx_extra_byte");
          else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e));
          end
        end
        if (frame_done) begin
          if (ev_q.size() == 0) flag("frame_done_extra");
          else begin
            ev = ev_q.pop_front();
            check("frame_done_kind", 32'(ev.kind == EV_DONE), 32'd1);
            check("frame_len", 32'(frame_len), 32'(ev.len));
          end
        end
        if (tx_err) begin
          if (ev_q.size() == 0) flag("tx_err_extra");
          else begin
            ev = ev_q.pop_front();
            check("tx_err_kind", 32'(ev.kind == EV_ERR), 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=no_finish want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] c;
    int acc;

    // Reference check of the CRC model against the standard "123456789" vector.
    c = '1;
    for (int i = 0; i < 9; i++) c = model_crc(c, 8'(8'h31 + i));
    if (~c !== 32'hCBF4_3926) begin
      $display("FAIL crc_model: got=0x%0h want=0xcbf43926", ~c);
      $fatal(1, "bench CRC model broken");
    end

    // Reset state
    #3;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    check("rst_frame_len", 32'(frame_len), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // 64-byte frame, line always ready
    expect_frame(64, 1, -1);
    drive_frame(64, 1, -1, acc);
    idle_inputs();
    wait_drain("drain_64");

    // 10-byte frame padded to 60
    expect_frame(10, 2, -1);
    drive_frame(10, 2, -1, acc);
    idle_inputs();
    wait_drain("drain_pad");
    check("len_after_pad", 32'(frame_len), 32'd60);

    // 100-byte frame under random line backpressure
    rand_ready = 1'b1;
    expect_frame(100, 3, -1);
    drive_frame(100, 3, -1, acc);
    idle_inputs();
    wait_drain("drain_random_ready");
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Underrun after 20 of 40 bytes
    expect_frame(40, 4, 20);
    drive_frame(40, 4, 20, acc);
    idle_inputs();
    check("underrun_accepted", 32'(acc), 32'd40);
    wait_drain("drain_underrun");
    check("len_after_underrun", 32'(frame_len), 32'd100);

    // Back-to-back frames with in_valid held high
    expect_frame(60, 7, -1);
    expect_frame(61, 8, -1);
    drive_frame(60, 7, -1, acc);
    drive_frame(61, 8, -1, acc);
    idle_inputs();
    wait_drain("drain_b2b");
    // IFG_BYTES gap cycles plus the IDLE cycle that samples in_valid
    check("ifg_gap", 32'(last_gap), 32'(IFG_BYTES + 1));

    // Reset while the second FCS byte is on the line
    expect_frame(60, 5, -1);
    drive_frame(60, 5, -1, acc);
    idle_inputs();
    @(posedge clk); #1;
    check("pre_rst_fcs_valid", 32'(tx_valid), 32'd1);
    check("pre_rst_fcs_left", 32'(exp_q.size()), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_frame_done", 32'(frame_done), 32'd0);
    check("mid_rst_tx_err", 32'(tx_err), 32'd0);
    check("mid_rst_frame_len", 32'(frame_len), 32'd0);
    exp_q.delete();
    ev_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Frame after reset starts with a full preamble and a fresh CRC
    expect_frame(64, 6, -1);
    drive_frame(64, 6, -1, acc);
    idle_inputs();
    wait_drain("drain_after_reset");
    check("len_after_reset", 32'(frame_len), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
